// File: rtl/mor1kx_cappuccino_pkg.sv
// Shared constants for the cappuccino RF access controller.
package mor1kx_cappuccino_pkg;

    localparam int unsigned SPR_ADDR_W  = 16;
    localparam int unsigned SPR_GROUP_W = 7;

    localparam logic [SPR_GROUP_W-1:0] SPR_GROUP_GPR = 7'h2;

    typedef enum logic [1:0] {
        RFC_INIT    = 2'd0,
        RFC_IDLE    = 2'd1,
        RFC_RD_WAIT = 2'd2,
        RFC_RD_ACK  = 2'd3
    } rfc_state_e;

endpackage

// File: rtl/mor1kx_rf_access_ctrl_cappuccino_if.sv
// SPR bus slice seen by the RF access controller: request from the bus, GPR ack/data back.
interface mor1kx_rf_access_ctrl_cappuccino_if
    import mor1kx_cappuccino_pkg::*;
#(
    parameter int unsigned DW = 32
);
    logic [SPR_ADDR_W-1:0] addr;
    logic                  stb;
    logic                  we;
    logic [DW-1:0]         dat;
    logic                  gpr_ack;
    logic [DW-1:0]         gpr_dat;

    modport master (output addr, stb, we, dat, input gpr_ack, gpr_dat);
    modport slave  (input addr, stb, we, dat, output gpr_ack, gpr_dat);

endinterface

// File: rtl/mor1kx_rf_access_ctrl_cappuccino.sv
// GPR file write-port arbiter, post-reset zero-fill walker and SPR-bus GPR read sequencer.
module mor1kx_rf_access_ctrl_cappuccino
    import mor1kx_cappuccino_pkg::*;
#(
    parameter int unsigned OPTION_OPERAND_WIDTH    = 32,
    parameter int unsigned OPTION_RF_ADDR_WIDTH    = 5,
    parameter int unsigned RF_ADDR_WIDTH           = 6,
    parameter int unsigned OPTION_RF_CLEAR_ON_INIT = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wb_rf_wb_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] result_i,
    input  logic                            padv_ctrl_i,
    mor1kx_rf_access_ctrl_cappuccino_if.slave spr,
    output logic                            rf_wren_o,
    output logic [RF_ADDR_WIDTH-1:0]        rf_wradr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] rf_wrdat_o,
    output logic                            rf_spr_re_o,
    output logic [RF_ADDR_WIDTH-1:0]        rf_spr_rdad_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] rf_spr_dout_i,
    output logic                            init_busy_o
);

    localparam int unsigned DW = OPTION_OPERAND_WIDTH;
    localparam int unsigned AW = RF_ADDR_WIDTH;
    localparam logic        CLEAR_ON_INIT = (OPTION_RF_CLEAR_ON_INIT != 0);
    localparam rfc_state_e  RST_STATE = CLEAR_ON_INIT ? RFC_INIT : RFC_IDLE;

    rfc_state_e    state_q, state_d;
    logic [AW-1:0] init_cnt_q, init_cnt_d;
    logic [AW-1:0] rd_adr_q, rd_adr_d;
    logic [DW-1:0] cap_dat_q, cap_dat_d;
    logic          byp_q, byp_d;
    logic [DW-1:0] byp_dat_q, byp_dat_d;

    logic          gpr_hit;
    logic [AW-1:0] spr_adr;
    logic [AW-1:0] wb_adr;
    logic          unused_spr_addr;

    assign gpr_hit         = (spr.addr[SPR_ADDR_W-1:SPR_ADDR_W-SPR_GROUP_W] == SPR_GROUP_GPR) & spr.stb;
    assign spr_adr         = spr.addr[AW-1:0];
    assign wb_adr          = AW'(wb_rfd_adr_i);
    assign unused_spr_addr = ^spr.addr;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= RST_STATE;
            init_cnt_q <= '0;
            rd_adr_q   <= '0;
            cap_dat_q  <= '0;
            byp_q      <= 1'b0;
            byp_dat_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            rd_adr_q   <= rd_adr_d;
            cap_dat_q  <= cap_dat_d;
            byp_q      <= byp_d;
            byp_dat_q  <= byp_dat_d;
        end
    end

    // Next state, write-port arbitration and read sequencing
    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        rd_adr_d      = rd_adr_q;
        cap_dat_d     = cap_dat_q;
        byp_d         = byp_q;
        byp_dat_d     = byp_dat_q;
        rf_wren_o     = 1'b0;
        rf_wradr_o    = '0;
        rf_wrdat_o    = '0;
        rf_spr_re_o   = 1'b0;
        rf_spr_rdad_o = '0;
        spr.gpr_ack   = 1'b0;
        spr.gpr_dat   = '0;
        init_busy_o   = 1'b0;

        case (state_q)
            RFC_INIT: begin
                rf_wren_o   = 1'b1;
                rf_wradr_o  = init_cnt_q;
                init_busy_o = 1'b1;
                init_cnt_d  = init_cnt_q + AW'(1);
                if (init_cnt_q == '1) state_d = RFC_IDLE;
            end
            RFC_IDLE: begin
                // Writeback owns the port; a pending SPR write just waits unacked
                if (wb_rf_wb_i) begin
                    rf_wren_o  = 1'b1;
                    rf_wradr_o = wb_adr;
                    rf_wrdat_o = result_i;
                end else if (gpr_hit && spr.we) begin
                    rf_wren_o   = 1'b1;
                    rf_wradr_o  = spr_adr;
                    rf_wrdat_o  = spr.dat;
                    spr.gpr_ack = 1'b1;
                end
                if (gpr_hit && !spr.we && !padv_ctrl_i) begin
                    rf_spr_re_o   = 1'b1;
                    rf_spr_rdad_o = spr_adr;
                    rd_adr_d      = spr_adr;
                    byp_d         = wb_rf_wb_i && (wb_adr == spr_adr);
                    byp_dat_d     = result_i;
                    state_d       = RFC_RD_WAIT;
                end
            end
            RFC_RD_WAIT: begin
                if (wb_rf_wb_i) begin
                    rf_wren_o  = 1'b1;
                    rf_wradr_o = wb_adr;
                    rf_wrdat_o = result_i;
                end
                if (!spr.stb) begin
                    state_d = RFC_IDLE;
                end else begin
                    state_d = RFC_RD_ACK;
                    // Newest writer wins: this-cycle writeback, then request-cycle writeback, then RAM
                    if (wb_rf_wb_i && (wb_adr == rd_adr_q)) cap_dat_d = result_i;
                    else if (byp_q)                         cap_dat_d = byp_dat_q;
                    else                                    cap_dat_d = rf_spr_dout_i;
                end
            end
            RFC_RD_ACK: begin
                if (wb_rf_wb_i) begin
                    rf_wren_o  = 1'b1;
                    rf_wradr_o = wb_adr;
                    rf_wrdat_o = result_i;
                end
                spr.gpr_ack = 1'b1;
                spr.gpr_dat = cap_dat_q;
                state_d     = RFC_IDLE;
            end
            default: state_d = RST_STATE;
        endcase

        if (!rst) begin
            rf_wren_o     = 1'b0;
            rf_wradr_o    = '0;
            rf_wrdat_o    = '0;
            rf_spr_re_o   = 1'b0;
            rf_spr_rdad_o = '0;
            spr.gpr_ack   = 1'b0;
            spr.gpr_dat   = '0;
            init_busy_o   = CLEAR_ON_INIT;
        end
    end

endmodule
